bf_tape_ctrl: RTL
=================

BF_TAPE_CTRL -- requirements
Module: bf_tape_ctrl

Interface
REQ-001 SHALL have parameter: logsize, 8, log2 of tape length in cells (tape = 2**logsize cells of 8 bits).
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge
- init_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd  in  3  0 NOP, 1 INC, 2 DEC, 3 LEFT, 4 RIGHT, 5 GET, 6 PUT, 7 CLEAR
- cmd_wdata  in  8  value for PUT
- cmd_ready  out  1  controller can accept a command
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  cell value after command; 0 for NOP/LEFT/RIGHT
- err  out  1  sticky tape-boundary error
- dp  out  logsize  current data pointer
- mem_addr  out  logsize  memory address
- mem_wdata  out  8  memory write data
- mem_wselect  out  1  1 = write, 0 = read
- mem_doit  out  1  memory access strobe
- mem_busy  in  1  memory cannot take an access
- mem_rvalid  in  1  mem_rdata valid (may be same cycle as mem_doit)
- mem_rdata  in  8  memory read data

Function
REQ-003 SHALL accept a command when cmd_valid & cmd_ready at a rising edge; cmd_ready SHALL be high only in IDLE.
REQ-004 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
REQ-005 IDLE on accept: INC/DEC/GET -> RD_REQ; PUT/CLEAR -> WR_REQ; LEFT/RIGHT/NOP -> RESP (dp updated at the accept edge).
REQ-006 RD_REQ SHALL drive mem_doit = !mem_busy, mem_wselect = 0, mem_addr = dp; on issue with mem_rvalid high, capture mem_rdata and advance; on issue without mem_rvalid -> RD_WAIT; if mem_busy, hold RD_REQ.
REQ-007 RD_WAIT SHALL keep mem_doit low and capture mem_rdata at the first mem_rvalid; then INC/DEC -> WR_REQ, GET -> RESP.
REQ-008 WR_REQ SHALL drive mem_doit = !mem_busy, mem_wselect = 1, mem_addr = dp, mem_wdata = new value; on issue -> RESP; if mem_busy, hold WR_REQ with mem_wdata stable.
REQ-009 New value: INC = old+1 mod 256 (255 -> 0); DEC = old-1 mod 256 (0 -> 255); PUT = cmd_wdata latched at accept; CLEAR = 0.
REQ-010 RESP SHALL assert rsp_valid for exactly one cycle, present rsp_data, and return to IDLE.
REQ-011 Latency with a zero-wait memory (accept at edge T): LEFT/RIGHT/NOP rsp_valid in cycle T+1; GET/PUT/CLEAR T+2; INC/DEC T+3.
REQ-012 mem_doit SHALL be high for exactly one cycle per access and never while mem_busy is high.
REQ-013 rsp_data SHALL hold its value until the next RESP.
REQ-014 cmd_valid while cmd_ready is low SHALL be ignored; no command queuing.
REQ-015 dp SHALL change only on accepted LEFT/RIGHT.

Reset
REQ-016 init_n low SHALL asynchronously force: state IDLE, dp 0, err 0, rsp_valid 0, rsp_data 0, mem_doit 0, mem_wselect 0, mem_addr 0, mem_wdata 0; cmd_ready SHALL be 1 once init_n is high.
REQ-017 Reset mid-operation SHALL abort the command with no further memory access and no rsp_valid; memory contents are not cleared by this block.

Configuration
REQ-018 Macro BF_TAPE_WRAP_EN defined: LEFT at dp 0 -> dp 2**logsize-1; RIGHT at dp max -> 0; err never set.
REQ-019 Macro undefined: LEFT at dp 0 or RIGHT at dp max SHALL leave dp unchanged, set err (sticky until reset), and still complete with rsp_valid.

Structure
REQ-020 Package bf_pkg SHALL hold the cmd encodings and the FSM state type; shared by bf_tape_ctrl and the bench.
REQ-021 Single module; no sub-module; the tape memory is external and connected by the bench.

Verification
REQ-022 Reset, zero-wait memory, INC x3 at dp 0 -> rsp_data 1, 2, 3; each rsp_valid 3 cycles after accept.
REQ-023 PUT 0xFF, INC -> rsp_data 0x00; CLEAR, DEC -> rsp_data 0xFF.
REQ-024 RIGHT, PUT 0x41, LEFT, GET -> rsp_data 0; RIGHT, GET -> 0x41; dp = 1.
REQ-025 LEFT at dp 0: with BF_TAPE_WRAP_EN dp = 2**logsize-1, err 0; without, dp 0, err 1 and stays 1 after later commands.
REQ-026 Memory with mem_busy high 3 cycles and mem_rvalid 2 cycles after doit, INC on 0x10 -> rsp_data 0x11; mem_doit never high with mem_busy; exactly 2 doit pulses.
REQ-027 init_n low during WR_REQ of INC -> no write, no rsp_valid, cell unchanged on subsequent GET.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the tape controller: command encodings, FSM state type
// and the cell update rule applied on the write leg of INC/DEC/PUT/CLEAR.
package bf_pkg;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_INC   = 3'd1;
  localparam logic [2:0] CMD_DEC   = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_GET   = 3'd5;
  localparam logic [2:0] CMD_PUT   = 3'd6;
  localparam logic [2:0] CMD_CLEAR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } bf_state_t;

  // Value written back to the current cell; 8-bit arithmetic wraps 255<->0.
  function automatic logic [7:0] bf_next_value(input logic [2:0] op,
                                               input logic [7:0] old,
                                               input logic [7:0] wdata);
    case (op)
      CMD_INC: return old + 8'd1;
      CMD_DEC: return old - 8'd1;
      CMD_PUT: return wdata;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bf_tape_ctrl.sv
// Tape controller: one command at a time against an external 8-bit tape memory.
// Optional macro BF_TAPE_WRAP_EN: data pointer wraps at the tape ends instead of raising err.
module bf_tape_ctrl
  import bf_pkg::*;
#(
  parameter int unsigned logsize = 8
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  input  logic [7:0]         cmd_wdata,
  output logic               cmd_ready,
  output logic               rsp_valid,
  output logic [7:0]         rsp_data,
  output logic               err,
  output logic [logsize-1:0] dp,
  output logic [logsize-1:0] mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               mem_wselect,
  output logic               mem_doit,
  input  logic               mem_busy,
  input  logic               mem_rvalid,
  input  logic [7:0]         mem_rdata
);

  bf_state_t  state;
  logic [2:0] op;
  logic [7:0] wval;
  logic [7:0] rdat;
  logic [7:0] newval;
  logic       accept;
  logic       rd_done;
  logic       wr_done;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign newval    = bf_next_value(op, rdat, wval);

  // Read completes either in the issue cycle (zero-wait memory) or later in RD_WAIT.
  assign rd_done = ((state == ST_RD_REQ) && !mem_busy && mem_rvalid) ||
                   ((state == ST_RD_WAIT) && mem_rvalid);
  assign wr_done = (state == ST_WR_REQ) && !mem_busy;

  always_comb begin
    mem_doit    = 1'b0;
    mem_wselect = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    rsp_valid   = 1'b0;
    case (state)
      ST_RD_REQ: begin
        mem_doit = !mem_busy;
        mem_addr = dp;
      end
      ST_WR_REQ: begin
        mem_doit    = !mem_busy;
        mem_wselect = 1'b1;
        mem_addr    = dp;
        mem_wdata   = newval;
      end
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= ST_IDLE;
      op       <= CMD_NOP;
      wval     <= '0;
      rdat     <= '0;
      dp       <= '0;
      err      <= 1'b0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op   <= cmd;
            wval <= cmd_wdata;
            case (cmd)
              CMD_INC, CMD_DEC, CMD_GET: state <= ST_RD_REQ;
              CMD_PUT, CMD_CLEAR:        state <= ST_WR_REQ;
              default: begin
                state    <= ST_RESP;
                rsp_data <= '0;
              end
            endcase
            if (cmd == CMD_LEFT) begin
`ifdef BF_TAPE_WRAP_EN
              dp <= dp - 1'b1;
`else
              if (dp == '0) err <= 1'b1;
              else          dp  <= dp - 1'b1;
`endif
            end
            if (cmd == CMD_RIGHT) begin
`ifdef BF_TAPE_WRAP_EN
              dp <= dp + 1'b1;
`else
              if (dp == '1) err <= 1'b1;
              else          dp  <= dp + 1'b1;
`endif
            end
          end
        end
        ST_RD_REQ, ST_RD_WAIT: begin
          if (rd_done) begin
            rdat <= mem_rdata;
            if (op == CMD_GET) begin
              rsp_data <= mem_rdata;
              state    <= ST_RESP;
            end else begin
              state <= ST_WR_REQ;
            end
          end else if (state == ST_RD_REQ && !mem_busy) begin
            state <= ST_RD_WAIT;
          end
        end
        ST_WR_REQ: begin
          if (wr_done) begin
            rsp_data <= newval;
            state    <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
